// File: rtl/ps2_cmd_scheduler_if.sv
// Key-event to game-command bus between the PS/2 decoder side and the PushBox game side.
// Latency: n/a, signal bundle only.
// Backpressure: consumer holds cmd_ack low to stall; the queue drops commands when full.
interface ps2_cmd_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [9:0]    key_data;
  logic          key_ready;
  logic          en;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic          cmd_ack;
  logic [7:0]    held;
  logic [LW-1:0] level;
  logic          overflow;
  logic          clr_ovf;

  modport master (
    output key_data, key_ready, en, cmd_ack, clr_ovf,
    input  cmd, cmd_valid, held, level, overflow
  );

  modport slave (
    input  key_data, key_ready, en, cmd_ack, clr_ovf,
    output cmd, cmd_valid, held, level, overflow
  );
endinterface

// File: rtl/ps2_cmd_scheduler.sv
// Maps decoded PS/2 key events to 3-bit game commands, drops auto-repeat, queues them FWFT.
// Latency: 1 cycle from key_ready to cmd_valid on an empty queue.
// Backpressure: head is held until cmd_ack; a push into a full queue without a pop is dropped.
module ps2_cmd_scheduler #(
  parameter int DEPTH     = 4,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  ps2_cmd_scheduler_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [7:0]    held_q;
  logic          overflow_q;

  logic          expand;
  logic          brk;
  logic [7:0]    code;
  logic          hit;
  logic [2:0]    dec_cmd;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          drop;

  assign expand = bus.key_data[9];
  assign brk    = bus.key_data[8];
  assign code   = bus.key_data[7:0];

  // Key map: both bindings of a direction resolve to the same command, anything else misses.
  always_comb begin
    hit     = 1'b1;
    dec_cmd = 3'd0;
    case ({expand, code})
      9'h175, 9'h01D: dec_cmd = 3'd0;
      9'h172, 9'h01B: dec_cmd = 3'd1;
      9'h16B, 9'h01C: dec_cmd = 3'd2;
      9'h174, 9'h023: dec_cmd = 3'd3;
      9'h03C:         dec_cmd = 3'd4;
      9'h02D:         dec_cmd = 3'd5;
      9'h05A:         dec_cmd = 3'd6;
      9'h076:         dec_cmd = 3'd7;
      default:        hit     = 1'b0;
    endcase
  end

  assign full     = (level_q == FULL_LVL);
  assign pop      = bus.cmd_valid && bus.cmd_ack;
  // A make of an already-held key is typematic repeat; only queued when repeats are wanted.
  assign push_req = bus.key_ready && hit && !brk && bus.en && (!held_q[dec_cmd] || REPEAT_EN);
  // A simultaneous pop frees the slot, so a full queue still accepts the push.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Queue storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 3'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= dec_cmd;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Key-down tracking follows make/break regardless of en or queue space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= 8'd0;
    end else if (bus.key_ready && hit) begin
      held_q[dec_cmd] <= !brk;
    end
  end

  // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.cmd_valid = (level_q != '0);
  assign bus.cmd       = bus.cmd_valid ? mem[rd_ptr] : 3'd0;
  assign bus.level     = level_q;
  assign bus.held      = held_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: two instances (repeat suppression on and off) share stimulus.
// Latency: expected queue contents kept per instance and compared at each pop.
// Backpressure: acks are issued explicitly by directed steps.
module tb_ps2_cmd_scheduler;
  logic clk;
  logic rst;

  int checks;
  int errors;

  ps2_cmd_scheduler_if #(.DEPTH(4)) bus_a ();
  ps2_cmd_scheduler_if #(.DEPTH(4)) bus_b ();

  ps2_cmd_scheduler #(.DEPTH(4), .REPEAT_EN(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ps2_cmd_scheduler #(.DEPTH(4), .REPEAT_EN(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.key_data  = bus_a.key_data;
  assign bus_b.key_ready = bus_a.key_ready;
  assign bus_b.en        = bus_a.en;
  assign bus_b.cmd_ack   = bus_a.cmd_ack;
  assign bus_b.clr_ovf   = bus_a.clr_ovf;

  logic [2:0] o_cmd   [2];
  logic       o_valid [2];
  logic [2:0] o_level [2];
  logic [7:0] o_held  [2];
  logic       o_ovf   [2];

  assign o_cmd[0]   = bus_a.cmd;
  assign o_cmd[1]   = bus_b.cmd;
  assign o_valid[0] = bus_a.cmd_valid;
  assign o_valid[1] = bus_b.cmd_valid;
  assign o_level[0] = bus_a.level;
  assign o_level[1] = bus_b.level;
  assign o_held[0]  = bus_a.held;
  assign o_held[1]  = bus_b.held;
  assign o_ovf[0]   = bus_a.overflow;
  assign o_ovf[1]   = bus_b.overflow;

  // Scoreboard: expected queue, held bits and overflow per instance (index 1 has repeats on).
  int         mq [2][$];
  logic [7:0] m_held [2];
  bit         m_ovf  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int map_key(input logic [9:0] d);
    case ({d[9], d[7:0]})
      9'h175, 9'h01D: return 0;
      9'h172, 9'h01B: return 1;
      9'h16B, 9'h01C: return 2;
      9'h174, 9'h023: return 3;
      9'h03C:         return 4;
      9'h02D:         return 5;
      9'h05A:         return 6;
      9'h076:         return 7;
      default:        return -1;
    endcase
  endfunction

  // Drive one clock cycle of inputs, update the expected state, compare any popped head.
  task automatic cycle(input logic [9:0] d, input bit kr, input bit ack, input bit clr);
    int c;
    bit full;
    bit pop;
    bit push_req;
    bit drop;
    bus_a.key_data  = d;
    bus_a.key_ready = kr;
    bus_a.cmd_ack   = ack;
    bus_a.clr_ovf   = clr;
    c = map_key(d);
    for (int i = 0; i < 2; i++) begin
      full = (mq[i].size() == 4);
      pop  = ack && (mq[i].size() != 0);
      if (pop) begin
        check($sformatf("pop_cmd%0d", i), 32'(o_cmd[i]), 32'(mq[i][0]));
        void'(mq[i].pop_front());
      end
      push_req = kr && (c >= 0) && !d[8] && bus_a.en && (!m_held[i][c] || (i == 1));
      drop = 1'b0;
      if (push_req) begin
        if (!full || pop) mq[i].push_back(c);
        else drop = 1'b1;
      end
      if (drop) m_ovf[i] = 1'b1;
      else if (clr) m_ovf[i] = 1'b0;
      if (kr && (c >= 0)) m_held[i][c] = !d[8];
    end
    @(posedge clk);
    #1;
    bus_a.key_ready = 1'b0;
    bus_a.cmd_ack   = 1'b0;
    bus_a.clr_ovf   = 1'b0;
    bus_a.key_data  = 10'h000;
  endtask

  task automatic chk(input string step);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_valid%0d", step, i), 32'(o_valid[i]), 32'(mq[i].size() != 0));
      check($sformatf("%s_level%0d", step, i), 32'(o_level[i]), 32'(mq[i].size()));
      check($sformatf("%s_held%0d", step, i), 32'(o_held[i]), 32'(m_held[i]));
      check($sformatf("%s_ovf%0d", step, i), 32'(o_ovf[i]), 32'(m_ovf[i]));
      if (mq[i].size() != 0)
        check($sformatf("%s_cmd%0d", step, i), 32'(o_cmd[i]), 32'(mq[i][0]));
    end
  endtask

  // Ack until both expected queues are empty; each pop is compared in cycle().
  task automatic drain(input string step);
    for (int n = 0; n < 20; n++) begin
      if (mq[0].size() == 0 && mq[1].size() == 0) break;
      cycle(10'h000, 1'b0, 1'b1, 1'b0);
    end
    chk(step);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_held[i] = 8'd0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst             = 1'b1;
    bus_a.key_data  = 10'h000;
    bus_a.key_ready = 1'b0;
    bus_a.en        = 1'b1;
    bus_a.cmd_ack   = 1'b0;
    bus_a.clr_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset");
    check("reset_cmd0", 32'(o_cmd[0]), 32'd0);
    check("reset_cmd1", 32'(o_cmd[1]), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single make on an empty queue, then ack.
    cycle(10'h275, 1'b1, 1'b0, 1'b0);
    chk("t1_push");
    cycle(10'h000, 1'b0, 1'b1, 1'b0);
    chk("t1_ack");

    // Held key repeats three times then breaks.
    cycle(10'h275, 1'b1, 1'b0, 1'b0);
    cycle(10'h275, 1'b1, 1'b0, 1'b0);
    cycle(10'h275, 1'b1, 1'b0, 1'b0);
    cycle(10'h375, 1'b1, 1'b0, 1'b0);
    chk("t2_repeat");
    drain("t2_drain");

    // Fill to DEPTH and overflow by one.
    cycle(10'h01D, 1'b1, 1'b0, 1'b0);
    cycle(10'h01B, 1'b1, 1'b0, 1'b0);
    cycle(10'h01C, 1'b1, 1'b0, 1'b0);
    cycle(10'h023, 1'b1, 1'b0, 1'b0);
    chk("t3_full");
    cycle(10'h03C, 1'b1, 1'b0, 1'b0);
    chk("t3_ovf");
    // Drop and clear in the same cycle: the set wins.
    cycle(10'h076, 1'b1, 1'b0, 1'b1);
    chk("t3_setwins");
    cycle(10'h000, 1'b0, 1'b0, 1'b1);
    chk("t3_clr");

    // Full queue, push with simultaneous ack; tail order checked while draining.
    cycle(10'h02D, 1'b1, 1'b1, 1'b0);
    chk("t4_pushpop");
    drain("t4_drain");

    // Release every key that is still down.
    cycle(10'h11D, 1'b1, 1'b0, 1'b0);
    cycle(10'h11B, 1'b1, 1'b0, 1'b0);
    cycle(10'h11C, 1'b1, 1'b0, 1'b0);
    cycle(10'h123, 1'b1, 1'b0, 1'b0);
    cycle(10'h13C, 1'b1, 1'b0, 1'b0);
    cycle(10'h12D, 1'b1, 1'b0, 1'b0);
    cycle(10'h176, 1'b1, 1'b0, 1'b0);
    chk("breaks");

    // Disabled make still tracks held; later make counts as repeat.
    bus_a.en = 1'b0;
    cycle(10'h01D, 1'b1, 1'b0, 1'b0);
    chk("t5_en0");
    bus_a.en = 1'b1;
    cycle(10'h01D, 1'b1, 1'b0, 1'b0);
    chk("t5_rep");
    cycle(10'h015, 1'b1, 1'b0, 1'b0);
    cycle(10'h23C, 1'b1, 1'b0, 1'b0);
    cycle(10'h25A, 1'b1, 1'b0, 1'b0);
    chk("t5_ignored");
    cycle(10'h11D, 1'b1, 1'b0, 1'b0);
    cycle(10'h01D, 1'b1, 1'b0, 1'b0);
    chk("t5_remake");
    drain("t5_drain");

    // Asynchronous reset in the middle of a non-empty queue.
    cycle(10'h01B, 1'b1, 1'b0, 1'b0);
    cycle(10'h01C, 1'b1, 1'b0, 1'b0);
    cycle(10'h023, 1'b1, 1'b0, 1'b0);
    chk("t6_pre");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(10'h01D, 1'b1, 1'b0, 1'b0);
    chk("t6_post");
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
